// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus: timing-generator inputs, writer handshake, memory port and scan-out.
// slave = arbiter side, master = driver side (timing gen, writer, RAM read data).
interface fb_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 4
);
    logic [9:0]    sx;
    logic [9:0]    sy;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          wr_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_color;
    logic          hsync_o;
    logic          vsync_o;
    logic          de_o;

    modport slave (
        input  sx, sy, hsync, vsync, de, wr_req, wr_addr, wr_data, mem_rdata,
        output wr_ack, wr_err, mem_addr, mem_we, mem_wdata, pix_color, hsync_o, vsync_o, de_o
    );

    modport master (
        output sx, sy, hsync, vsync, de, wr_req, wr_addr, wr_data, mem_rdata,
        input  wr_ack, wr_err, mem_addr, mem_we, mem_wdata, pix_color, hsync_o, vsync_o, de_o
    );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads every 4th active pixel, scan-out 3 cycles after the slot.
// Display never stalls; writer waits (wr_req held) until wr_ack, at most one grant per two cycles.
module fb_arbiter #(
    parameter int FB_W           = 160,
    parameter int FB_H           = 120,
    parameter int AW             = 15,
    parameter int DW             = 4,
    parameter int WR_VBLANK_ONLY = 0
) (
    input  logic          clk_pix,
    input  logic          rst_pix,
    fb_arbiter_if.slave   bus
);
    localparam logic [AW:0] FB_SIZE = (AW+1)'(FB_W * FB_H);

    logic          disp_slot;
    logic [AW-1:0] disp_addr;
    logic          vblank_ok;
    logic          in_range;
    logic          grant;

    logic [AW-1:0] mem_addr_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_wdata_q;
    logic          wr_ack_q;
    logic          wr_err_q;
    logic [DW-1:0] pix_q;
    logic [1:0]    slot_d;
    logic [2:0]    hs_d;
    logic [2:0]    vs_d;
    logic [2:0]    de_d;

    assign disp_slot = bus.de && (bus.sx[1:0] == 2'b00);
    assign disp_addr = AW'(bus.sy[9:2]) * AW'(FB_W) + AW'(bus.sx[9:2]);
    assign vblank_ok = (WR_VBLANK_ONLY == 0) || (bus.sy >= 10'd480);
    assign in_range  = {1'b0, bus.wr_addr} < FB_SIZE;
    // Blocking on wr_ack caps the write rate and lets the writer see the ack before re-arming.
    assign grant     = bus.wr_req && !disp_slot && !wr_ack_q && vblank_ok;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            pix_q       <= '0;
            slot_d      <= '0;
            hs_d        <= '0;
            vs_d        <= '0;
            de_d        <= '0;
        end else begin
            mem_we_q <= 1'b0;
            wr_ack_q <= 1'b0;
            slot_d   <= {slot_d[0], disp_slot};
            hs_d     <= {hs_d[1:0], bus.hsync};
            vs_d     <= {vs_d[1:0], bus.vsync};
            de_d     <= {de_d[1:0], bus.de};
            // Read data returns the cycle after the address; capture it two cycles after the slot.
            if (slot_d[1]) begin
                pix_q <= bus.mem_rdata;
            end
            if (disp_slot) begin
                mem_addr_q <= disp_addr;
            end else if (grant) begin
                wr_ack_q <= 1'b1;
                if (in_range) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= bus.wr_addr;
                    mem_wdata_q <= bus.wr_data;
                end else begin
                    wr_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.hsync_o   = hs_d[2];
    assign bus.vsync_o   = vs_d[2];
    assign bus.de_o      = de_d[2];
    assign bus.pix_color = de_d[2] ? pix_q : '0;
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios then randomized traffic against a cycle-level reference model.
module tb_fb_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_arbiter_if #(.AW(15), .DW(4)) bus0 ();
    fb_arbiter_if #(.AW(15), .DW(4)) bus1 ();

    fb_arbiter #(.FB_W(160), .FB_H(120), .AW(15), .DW(4), .WR_VBLANK_ONLY(0)) u_dut (
        .clk_pix(clk), .rst_pix(rst), .bus(bus0.slave));
    fb_arbiter #(.FB_W(160), .FB_H(120), .AW(15), .DW(4), .WR_VBLANK_ONLY(1)) u_dut_vb (
        .clk_pix(clk), .rst_pix(rst), .bus(bus1.slave));

    assign bus1.sx        = bus0.sx;
    assign bus1.sy        = bus0.sy;
    assign bus1.hsync     = bus0.hsync;
    assign bus1.vsync     = bus0.vsync;
    assign bus1.de        = bus0.de;
    assign bus1.wr_req    = bus0.wr_req;
    assign bus1.wr_addr   = bus0.wr_addr;
    assign bus1.wr_data   = bus0.wr_data;
    assign bus1.mem_rdata = 4'h0;

    // RAM stores data XOR the low address bits so unwritten locations read back as varied colours.
    bit [3:0] fbmem [32768];
    always @(posedge clk) begin
        if (bus0.mem_we) fbmem[bus0.mem_addr] <= bus0.mem_wdata ^ bus0.mem_addr[3:0];
        bus0.mem_rdata <= fbmem[bus0.mem_addr] ^ bus0.mem_addr[3:0];
    end

    function automatic logic [3:0] mem_read(input logic [14:0] a);
        return fbmem[a] ^ a[3:0];
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { int due; logic [3:0] col; } pend_t;
    pend_t       pq [$];
    logic [2:0]  sp [$];
    logic [3:0]  cur_pix;
    logic        e_ack [2];
    logic        e_we  [2];
    logic        e_err [2];
    logic [14:0] e_addr;
    logic [3:0]  e_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        logic        r;
        logic        slot;
        logic [14:0] a;
        logic [2:0]  so;
        r    = rst;
        slot = bus0.de && (int'(bus0.sx) % 4 == 0);
        a    = 15'((int'(bus0.sy) / 4) * 160 + int'(bus0.sx) / 4);
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                e_ack[k] = 1'b0; e_we[k] = 1'b0; e_err[k] = 1'b0;
            end
            e_addr = '0; e_wd = '0; cur_pix = '0;
            pq.delete(); sp.delete();
            for (int k = 0; k < 3; k++) sp.push_back(3'b000);
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic g;
                g = bus0.wr_req && !slot && !e_ack[k] && (k == 0 || int'(bus0.sy) >= 480);
                e_we[k] = g && (int'(bus0.wr_addr) < 19200);
                if (g && int'(bus0.wr_addr) >= 19200) e_err[k] = 1'b1;
                if (k == 0) begin
                    if (slot) e_addr = a;
                    else if (e_we[0]) begin e_addr = bus0.wr_addr; e_wd = bus0.wr_data; end
                end
                e_ack[k] = g;
            end
            sp.push_back({bus0.hsync, bus0.vsync, bus0.de});
            void'(sp.pop_front());
        end
        @(posedge clk); #1; cyc++;
        if (!r && slot) pq.push_back('{due: cyc + 2, col: mem_read(a)});
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            cur_pix = pq[0].col;
            void'(pq.pop_front());
        end
        so = sp[0];
        chk("hsync_o", 32'(bus0.hsync_o), 32'(so[2]));
        chk("vsync_o", 32'(bus0.vsync_o), 32'(so[1]));
        chk("de_o", 32'(bus0.de_o), 32'(so[0]));
        chk("pix_color", 32'(bus0.pix_color), so[0] ? 32'(cur_pix) : 32'd0);
        chk("mem_addr", 32'(bus0.mem_addr), 32'(e_addr));
        chk("mem_we", 32'(bus0.mem_we), 32'(e_we[0]));
        if (e_we[0] || r) chk("mem_wdata", 32'(bus0.mem_wdata), 32'(e_wd));
        chk("wr_ack", 32'(bus0.wr_ack), 32'(e_ack[0]));
        chk("wr_err", 32'(bus0.wr_err), 32'(e_err[0]));
        chk("vb_wr_ack", 32'(bus1.wr_ack), 32'(e_ack[1]));
        chk("vb_mem_we", 32'(bus1.mem_we), 32'(e_we[1]));
        chk("vb_wr_err", 32'(bus1.wr_err), 32'(e_err[1]));
    endtask

    task automatic set_pos(input int x, input int y, input logic d);
        bus0.sx = 10'(x); bus0.sy = 10'(y); bus0.de = d;
        bus0.hsync = 1'($urandom_range(0, 1)); bus0.vsync = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int acks;
        int b2b;
        logic prev_ack;
        rst = 1'b1;
        bus0.wr_req = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
        set_pos(0, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin e_ack[k] = 1'b0; e_we[k] = 1'b0; e_err[k] = 1'b0; end
        e_addr = '0; e_wd = '0; cur_pix = '0;
        step(); step();
        chk("rst_pix_color", 32'(bus0.pix_color), 32'd0);
        chk("rst_mem_addr", 32'(bus0.mem_addr), 32'd0);
        rst = 1'b0;

        // Display read of pixel (0,0) and the far corner.
        set_pos(0, 0, 1'b1); step();
        chk("disp_addr0", 32'(bus0.mem_addr), 32'd0);
        set_pos(1, 0, 1'b1); step();
        set_pos(2, 0, 1'b1); step();
        chk("pix0", 32'(bus0.pix_color), 32'(mem_read(15'd0)));
        set_pos(636, 479, 1'b1); step();
        chk("disp_max", 32'(bus0.mem_addr), 32'd19199);
        set_pos(637, 479, 1'b1); step();

        // Write colliding with a display slot waits one cycle.
        set_pos(0, 8, 1'b1);
        bus0.wr_req = 1'b1; bus0.wr_addr = 15'd100; bus0.wr_data = 4'hA;
        step();
        chk("collide_ack0", 32'(bus0.wr_ack), 32'd0);
        set_pos(1, 8, 1'b1); step();
        chk("collide_ack1", 32'(bus0.wr_ack), 32'd1);
        chk("collide_we", 32'(bus0.mem_we), 32'd1);
        chk("collide_addr", 32'(bus0.mem_addr), 32'd100);
        chk("collide_data", 32'(bus0.mem_wdata), 32'hA);
        bus0.wr_req = 1'b0;
        set_pos(700, 8, 1'b0); step();

        // Six blanking cycles of continuous requests.
        bus0.wr_req = 1'b1; bus0.wr_addr = 15'd200; bus0.wr_data = 4'h3;
        acks = 0; b2b = 0; prev_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_pos(700 + i, 8, 1'b0); step();
            if (bus0.wr_ack) begin
                acks++;
                if (prev_ack) b2b++;
                bus0.wr_addr = bus0.wr_addr + 15'd1;
                bus0.wr_data = 4'($urandom);
            end
            prev_ack = bus0.wr_ack;
        end
        chk("burst_acks", 32'(acks), 32'd3);
        chk("burst_b2b", 32'(b2b), 32'd0);
        bus0.wr_req = 1'b0; step();

        // Out-of-range address.
        bus0.wr_req = 1'b1; bus0.wr_addr = 15'd19200; bus0.wr_data = 4'h7;
        set_pos(710, 20, 1'b0); step();
        chk("oor_ack", 32'(bus0.wr_ack), 32'd1);
        chk("oor_we", 32'(bus0.mem_we), 32'd0);
        chk("oor_err", 32'(bus0.wr_err), 32'd1);
        bus0.wr_req = 1'b0; step(); step();
        chk("oor_err_sticky", 32'(bus0.wr_err), 32'd1);

        // Vblank-only instance ignores requests until sy reaches 480.
        bus0.wr_req = 1'b1; bus0.wr_addr = 15'd300; bus0.wr_data = 4'h5;
        for (int i = 0; i < 5; i++) begin
            set_pos(720, 100, 1'b0); step();
            chk("vb_hold", 32'(bus1.wr_ack), 32'd0);
        end
        set_pos(720, 480, 1'b0); step();
        chk("vb_ack", 32'(bus1.wr_ack), 32'd1);
        chk("vb_we", 32'(bus1.mem_we), 32'd1);
        bus0.wr_req = 1'b0; step(); step();

        // Reset asserted in a grant cycle.
        bus0.wr_req = 1'b1; bus0.wr_addr = 15'd50; bus0.wr_data = 4'h9;
        set_pos(730, 490, 1'b0); rst = 1'b1; step();
        chk("rstw_we", 32'(bus0.mem_we), 32'd0);
        chk("rstw_ack", 32'(bus0.wr_ack), 32'd0);
        chk("rstw_err", 32'(bus0.wr_err), 32'd0);
        rst = 1'b0; bus0.wr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin set_pos(i, 0, 1'b1); step(); end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int x;
            int y;
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 524);
            set_pos(x, y, (x < 640) && (y < 480));
            rst = ($urandom_range(0, 299) == 0);
            step();
            if (bus0.wr_req) begin
                if (bus0.wr_ack) begin
                    if ($urandom_range(0, 3) == 0) bus0.wr_req = 1'b0;
                    else begin
                        bus0.wr_addr = ($urandom_range(0, 15) == 0) ? 15'($urandom_range(19200, 32767))
                                                                     : 15'($urandom_range(0, 19199));
                        bus0.wr_data = 4'($urandom);
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus0.wr_req  = 1'b1;
                bus0.wr_addr = ($urandom_range(0, 15) == 0) ? 15'($urandom_range(19200, 32767))
                                                             : 15'($urandom_range(0, 19199));
                bus0.wr_data = 4'($urandom);
            end
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
